fractal_sync_req_arb: RTL and testbench

Round-robin arbiter and transaction tracker that shares one upstream fractal-sync request port among `N_REQ` local requesters (CU controllers or BFM masters). It sits between the requesters and the `IN` port of a 1-D fractal sync node. It serialises their sync requests and tags each request with the requester index. It routes each returned wake/error back to the issuing requester and, optionally, times out stuck barriers.

---
 rtl/fractal_sync_pkg.sv | 6 +
 rtl/fractal_sync_rr_arb.sv | 43 ++++
 rtl/fractal_sync_req_arb.sv | 128 ++++++++++++
 tb/tb_fractal_sync_req_arb.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fractal_sync_pkg.sv
// fractal_sync_pkg: shared types for the fractal-sync request arbiter
package fractal_sync_pkg;

    typedef enum logic [1:0] {IDLE, PEND, WAIT} fsync_arb_state_e;

endpackage

// File: rtl/fractal_sync_rr_arb.sv
// fractal_sync_rr_arb: N-input round-robin arbiter with pointer register and one-hot grant
module fractal_sync_rr_arb #(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [N-1:0] req_i,
    output logic [N-1:0] gnt_o,
    output logic [W-1:0] idx_o,
    output logic         valid_o
);

    logic [W-1:0] ptr_q;
    logic [W-1:0] lo;
    logic [W-1:0] hi;
    logic         hi_any;

    // lowest request at/above the pointer wins, else wrap to the lowest request overall
    always_comb begin
        lo     = '0;
        hi     = '0;
        hi_any = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[i]) lo = W'(i);
            if (req_i[i] && i >= int'(ptr_q)) begin
                hi     = W'(i);
                hi_any = 1'b1;
            end
        end
    end

    assign valid_o = |req_i;
    assign idx_o   = hi_any ? hi : lo;
    assign gnt_o   = valid_o ? (N'(1) << idx_o) : '0;

    // pointer moves to one past the winner
    always_ff @(posedge clk_i) begin
        if (rst_i)        ptr_q <= '0;
        else if (valid_o) ptr_q <= (int'(idx_o) == N - 1) ? '0 : idx_o + 1'b1;
    end

endmodule

// File: rtl/fractal_sync_req_arb.sv
// fractal_sync_req_arb: shares one fractal-sync request port among N_REQ requesters; FSYNC_ARB_TIMEOUT_EN adds WAIT timeouts
module fractal_sync_req_arb
    import fractal_sync_pkg::*;
#(
    parameter int N_REQ  = 4,
    parameter int AGGR_W = 6,
    parameter int ID_W   = 5,
    parameter int SRC_W  = $clog2(N_REQ),
    parameter int TO_W   = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [N_REQ-1:0]        req_valid_i,
    output logic [N_REQ-1:0]        req_ready_o,
    input  logic [N_REQ*AGGR_W-1:0] req_aggr_i,
    input  logic [N_REQ*ID_W-1:0]   req_id_i,
    output logic [N_REQ-1:0]        wake_o,
    output logic [N_REQ-1:0]        error_o,
    output logic                    sync_o,
    output logic [AGGR_W-1:0]       aggr_o,
    output logic [ID_W-1:0]         id_o,
    output logic [SRC_W-1:0]        src_o,
    input  logic                    wake_i,
    input  logic [SRC_W-1:0]        dst_i,
    input  logic                    error_i,
`ifdef FSYNC_ARB_TIMEOUT_EN
    input  logic [TO_W-1:0]         to_limit_i,
`endif
    output logic                    spurious_o
);

    logic [N_REQ-1:0]             pend;
    logic [N_REQ-1:0]             waiting;
    logic [N_REQ-1:0]             hit;
    logic [N_REQ-1:0]             done;
    logic [N_REQ-1:0]             err_d;
    logic [N_REQ-1:0]             gnt;
    logic [N_REQ-1:0][AGGR_W-1:0] aggr_all;
    logic [N_REQ-1:0][ID_W-1:0]   id_all;
    logic [SRC_W-1:0]             gnt_idx;
    logic                         gnt_any;

    fractal_sync_rr_arb #(.N(N_REQ), .W(SRC_W)) u_arb (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .req_i   (pend),
        .gnt_o   (gnt),
        .idx_o   (gnt_idx),
        .valid_o (gnt_any)
    );

    for (genvar g = 0; g < N_REQ; g++) begin : g_req
        fsync_arb_state_e  state_q;
        fsync_arb_state_e  state_d;
        logic [AGGR_W-1:0] aggr_q;
        logic [ID_W-1:0]   id_q;
        logic              to_hit;
`ifdef FSYNC_ARB_TIMEOUT_EN
        logic [TO_W-1:0]   cnt_q;
        // counts cycles spent in WAIT, cleared outside it, saturating
        always_ff @(posedge clk_i) begin
            if (rst_i || state_q != WAIT) cnt_q <= '0;
            else if (cnt_q != '1)         cnt_q <= cnt_q + 1'b1;
        end
        // fires on the cycle the counter is about to reach the limit
        assign to_hit = state_q == WAIT && to_limit_i != '0 &&
                        ({1'b0, cnt_q} + 1'b1) == {1'b0, to_limit_i};
`else
        assign to_hit = 1'b0;
`endif
        assign hit[g]         = wake_i && dst_i == SRC_W'(g);
        assign done[g]        = state_q == WAIT && (hit[g] || to_hit);
        assign err_d[g]       = hit[g] ? error_i : to_hit;
        assign pend[g]        = state_q == PEND;
        assign waiting[g]     = state_q == WAIT;
        assign req_ready_o[g] = state_q == IDLE;
        assign aggr_all[g]    = aggr_q;
        assign id_all[g]      = id_q;

        // IDLE -> PEND on handshake, PEND -> WAIT on grant, WAIT -> IDLE on wake/timeout
        always_comb begin
            state_d = state_q == IDLE ? (req_valid_i[g] ? PEND : IDLE)
                    : state_q == PEND ? (gnt[g] ? WAIT : PEND)
                    : done[g] ? IDLE : WAIT;
        end

        // per-requester state register
        always_ff @(posedge clk_i) begin
            if (rst_i) state_q <= IDLE;
            else       state_q <= state_d;
        end

        // capture the request payload on handshake
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                aggr_q <= '0;
                id_q   <= '0;
            end else if (state_q == IDLE && req_valid_i[g]) begin
                aggr_q <= req_aggr_i[g*AGGR_W +: AGGR_W];
                id_q   <= req_id_i[g*ID_W +: ID_W];
            end
        end
    end

    // registered upstream issue, downstream wake/error and sticky spurious flag
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wake_o     <= '0;
            error_o    <= '0;
            sync_o     <= 1'b0;
            aggr_o     <= '0;
            id_o       <= '0;
            src_o      <= '0;
            spurious_o <= 1'b0;
        end else begin
            wake_o     <= done;
            error_o    <= done & err_d;
            sync_o     <= gnt_any;
            spurious_o <= spurious_o | (wake_i && !(|(hit & waiting)));
            if (gnt_any) begin
                aggr_o <= aggr_all[gnt_idx];
                id_o   <= id_all[gnt_idx];
                src_o  <= gnt_idx;
            end
        end
    end

endmodule

// File: tb/tb_fractal_sync_req_arb.sv
// tb_fractal_sync_req_arb: directed self-checking bench for fractal_sync_req_arb (timeout cases under FSYNC_ARB_TIMEOUT_EN)
module tb_fractal_sync_req_arb;

    logic        clk = 1'b0;
    logic        rst_i;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [23:0] req_aggr;
    logic [19:0] req_id;
    logic [3:0]  wake_o;
    logic [3:0]  error_o;
    logic        sync_o;
    logic [5:0]  aggr_o;
    logic [4:0]  id_o;
    logic [1:0]  src_o;
    logic        wake_i;
    logic [1:0]  dst_i;
    logic        error_i;
    logic        spurious_o;
`ifdef FSYNC_ARB_TIMEOUT_EN
    logic [15:0] to_limit;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    fractal_sync_req_arb dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_aggr_i  (req_aggr),
        .req_id_i    (req_id),
        .wake_o      (wake_o),
        .error_o     (error_o),
        .sync_o      (sync_o),
        .aggr_o      (aggr_o),
        .id_o        (id_o),
        .src_o       (src_o),
        .wake_i      (wake_i),
        .dst_i       (dst_i),
        .error_i     (error_i),
`ifdef FSYNC_ARB_TIMEOUT_EN
        .to_limit_i  (to_limit),
`endif
        .spurious_o  (spurious_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [5:0] a, input logic [4:0] id);
        req_valid[i]        = 1'b1;
        req_aggr[i*6 +: 6]  = a;
        req_id[i*5 +: 5]    = id;
    endtask

    task automatic wake(input logic [1:0] d, input logic e);
        wake_i  = 1'b1;
        dst_i   = d;
        error_i = e;
        tick();
        wake_i  = 1'b0;
        error_i = 1'b0;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        tick();
        tick();
        rst_i = 1'b0;
    endtask

    task automatic check_reset_values();
        check("rst_ready", req_ready, 4'hF);
        check("rst_wake", wake_o, 0);
        check("rst_error", error_o, 0);
        check("rst_sync", sync_o, 0);
        check("rst_aggr", aggr_o, 0);
        check("rst_id", id_o, 0);
        check("rst_src", src_o, 0);
        check("rst_spurious", spurious_o, 0);
    endtask

    initial begin
        rst_i     = 1'b1;
        req_valid = '0;
        req_aggr  = '0;
        req_id    = '0;
        wake_i    = 1'b0;
        dst_i     = '0;
        error_i   = 1'b0;
`ifdef FSYNC_ARB_TIMEOUT_EN
        to_limit  = '0;
`endif
        do_reset();
        check_reset_values();

        // single request from requester 2
        set_req(2, 6'd1, 5'd0);
        tick();
        req_valid = '0;
        check("single_ready_pend", req_ready, 4'b1011);
        check("single_sync_early", sync_o, 0);
        tick();
        check("single_sync", sync_o, 1);
        check("single_src", src_o, 2);
        check("single_aggr", aggr_o, 1);
        check("single_id", id_o, 0);
        tick();
        check("single_sync_once", sync_o, 0);
        repeat (8) tick();
        check("single_no_wake_yet", wake_o, 0);
        wake(2'd2, 1'b0);
        check("single_wake", wake_o, 4'b0100);
        check("single_error", error_o, 0);
        check("single_ready_back", req_ready, 4'hF);
        tick();
        check("single_wake_pulse", wake_o, 0);
        check("single_no_spurious", spurious_o, 0);

        // contention: pointer sits at 3 after granting requester 2
        for (int i = 0; i < 4; i++) set_req(i, 6'(10 + i), 5'(20 + i));
        tick();
        req_valid = '0;
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("cont_sync%0d", k), sync_o, 1);
            check($sformatf("cont_src%0d", k), src_o, (3 + k) % 4);
            check($sformatf("cont_aggr%0d", k), aggr_o, 10 + (3 + k) % 4);
            check($sformatf("cont_id%0d", k), id_o, 20 + (3 + k) % 4);
        end
        tick();
        check("cont_sync_end", sync_o, 0);
        check("cont_all_wait", req_ready, 0);

        // error propagation to requester 1 only
        wake(2'd1, 1'b1);
        check("err_wake", wake_o, 4'b0010);
        check("err_error", error_o, 4'b0010);
        check("err_ready", req_ready, 4'b0010);
        wake(2'd0, 1'b0);
        check("w0_wake", wake_o, 4'b0001);
        check("w0_error", error_o, 0);
        wake(2'd2, 1'b0);
        check("w2_wake", wake_o, 4'b0100);
        wake(2'd3, 1'b0);
        check("w3_wake", wake_o, 4'b1000);
        tick();
        check("all_idle", req_ready, 4'hF);
        check("no_spurious_yet", spurious_o, 0);

        // second round starts at the rotated pointer (3)
        for (int i = 0; i < 4; i++) set_req(i, 6'(30 + i), 5'(i));
        tick();
        req_valid = '0;
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("rnd2_src%0d", k), src_o, (3 + k) % 4);
            check($sformatf("rnd2_aggr%0d", k), aggr_o, 30 + (3 + k) % 4);
        end
        for (int i = 0; i < 4; i++) begin
            wake(2'(i), 1'b0);
            check($sformatf("rnd2_wake%0d", i), wake_o, 4'b0001 << i);
        end

        // spurious wake for idle requester 3
        wake(2'd3, 1'b0);
        check("spur_no_wake", wake_o, 0);
        check("spur_set", spurious_o, 1);
        repeat (3) tick();
        check("spur_sticky", spurious_o, 1);

        // requesters 0 and 2 go to WAIT, then reset mid-WAIT
        set_req(0, 6'd7, 5'd3);
        set_req(2, 6'd9, 5'd4);
        tick();
        req_valid = '0;
        tick();
        check("mid_src_a", src_o, 0);
        tick();
        check("mid_src_b", src_o, 2);
        check("mid_aggr_b", aggr_o, 9);
        tick();
        check("mid_waiting", req_ready, 4'b1010);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        check_reset_values();

        // new request accepted normally after reset, pointer back at 0
        set_req(1, 6'd5, 5'd7);
        tick();
        req_valid = '0;
        tick();
        check("post_sync", sync_o, 1);
        check("post_src", src_o, 1);
        check("post_aggr", aggr_o, 5);
        check("post_id", id_o, 7);
        wake(2'd2, 1'b0);
        check("abandoned_no_wake", wake_o, 0);
        check("abandoned_spurious", spurious_o, 1);
        wake(2'd1, 1'b1);
        check("post_wake", wake_o, 4'b0010);
        check("post_error", error_o, 4'b0010);

`ifdef FSYNC_ARB_TIMEOUT_EN
        do_reset();
        to_limit = 16'd20;
        set_req(0, 6'd2, 5'd2);
        tick();
        req_valid = '0;
        tick();
        check("to_sync", sync_o, 1);
        repeat (19) tick();
        check("to_not_yet", wake_o, 0);
        tick();
        check("to_wake", wake_o, 4'b0001);
        check("to_error", error_o, 4'b0001);
        check("to_no_spur", spurious_o, 0);
        wake(2'd0, 1'b0);
        check("to_late_spur", spurious_o, 1);
        do_reset();
        to_limit = 16'd20;
        set_req(0, 6'd2, 5'd2);
        tick();
        req_valid = '0;
        tick();
        repeat (19) tick();
        wake(2'd0, 1'b0);
        check("to_race_wake", wake_o, 4'b0001);
        check("to_race_error", error_o, 0);
        check("to_race_spur", spurious_o, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
